// File: rtl/dsp_mac_chain.sv
// dsp_mac_chain: LANES signed multipliers feeding a sum / cascade / accumulate stage.
// Three-stage pipeline: operand register (per lane), product register (per lane),
// sum/accumulate register (drives the outputs).
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_in_valid     qualifies i_a, i_b, i_mode, i_cascade_in
//   i_a, i_b       LANES x IN_W signed operands, lane i at [i*IN_W +: IN_W]
//   i_mode         00 products, 01 sum, 10 sum+cascade (saturating), 11 accumulate
//   i_cascade_in   signed chain input, travels with its sample
//   i_acc_len      samples per accumulation (0 acts as 1), sampled when an
//                  accumulation starts at stage 3
//   i_clear        synchronous accumulator clear, acts on stage 3
//   o_out_valid    qualifies o_result, o_cascade_out, o_ovf
//   o_result       lane products (mode 00) or sign-extended scalar result
//   o_cascade_out  saturated sum / accumulator for the next block
//   o_ovf          saturation flag of the qualified result

// Per-lane operand and product registers.
module dsp_mac_lane #(
  parameter int IN_W = 18
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en1,
  input  logic                     i_en2,
  input  logic signed [IN_W-1:0]   i_a,
  input  logic signed [IN_W-1:0]   i_b,
  output logic signed [2*IN_W-1:0] o_p
);
  logic signed [IN_W-1:0]   r_a, r_b;
  logic signed [2*IN_W-1:0] r_p;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else begin
      if (i_en1) begin
        r_a <= i_a;
        r_b <= i_b;
      end
      if (i_en2) r_p <= r_a * r_b;
    end
  end

  assign o_p = r_p;
endmodule

module dsp_mac_chain #(
  parameter int IN_W  = 18,
  parameter int LANES = 4,
  parameter int ACC_W = 44,
  parameter int CNT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_valid,
  input  logic [LANES*IN_W-1:0]   i_a,
  input  logic [LANES*IN_W-1:0]   i_b,
  input  logic [1:0]              i_mode,
  input  logic [ACC_W-1:0]        i_cascade_in,
  input  logic [CNT_W-1:0]        i_acc_len,
  input  logic                    i_clear,
  output logic                    o_out_valid,
  output logic [LANES*2*IN_W-1:0] o_result,
  output logic [ACC_W-1:0]        o_cascade_out,
  output logic                    o_ovf
);
  localparam int LG = $clog2(LANES);
  localparam int PW = 2 * IN_W;
  localparam int SW = PW + LG;
  localparam int RW = LANES * PW;
  localparam int XW = (RW > ACC_W) ? RW : ACC_W;

  if (LANES < 1 || LANES > 8) begin : g_bad_lanes
    $error("dsp_mac_chain: LANES must be 1..8");
  end
  if (ACC_W < SW) begin : g_bad_accw
    $error("dsp_mac_chain: ACC_W too small for exact lane sum");
  end

  // ---------------- stages 1-2: lanes + sideband pipeline ----------------
  logic [1:0]                  r_vld_pipe;      // [0] stage 1, [1] stage 2
  logic [1:0][1:0]             r_mode_pipe;
  logic [1:0][ACC_W-1:0]       r_casc_pipe;
  logic [LANES-1:0][PW-1:0]    w_p;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dsp_mac_lane #(.IN_W(IN_W)) u_lane (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en1  (i_in_valid),
      .i_en2  (r_vld_pipe[0]),
      .i_a    (i_a[l*IN_W +: IN_W]),
      .i_b    (i_b[l*IN_W +: IN_W]),
      .o_p    (w_p[l])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe  <= '0;
      r_mode_pipe <= '0;
      r_casc_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], i_in_valid};
      if (i_in_valid) begin
        r_mode_pipe[0] <= i_mode;
        r_casc_pipe[0] <= i_cascade_in;
      end
      if (r_vld_pipe[0]) begin
        r_mode_pipe[1] <= r_mode_pipe[0];
        r_casc_pipe[1] <= r_casc_pipe[0];
      end
    end
  end

  // ---------------- stage 3: sum / cascade / accumulate ----------------
  // Returns {saturated, value}; overflow shows as disagreeing top two bits.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] x,
                                             input logic signed [ACC_W-1:0] y);
    logic signed [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    if (s[ACC_W] != s[ACC_W-1]) sat_add = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    else                        sat_add = {1'b0, s[ACC_W-1:0]};
  endfunction

  function automatic logic [RW-1:0] sext_r(input logic signed [ACC_W-1:0] v);
    logic signed [XW-1:0] t;
    t = XW'(v);
    sext_r = t[RW-1:0];
  endfunction

  logic [CNT_W-1:0]        r_cnt, r_len_q;
  logic [ACC_W-1:0]        r_acc;
  logic                    r_ovf_acc;

  logic signed [SW-1:0]    w_s;
  logic signed [ACC_W-1:0] w_s_ext, w_t, w_acc_sum, w_acc_next;
  logic                    w_t_sat, w_acc_sat, w_step_ovf, w_ovf_all, w_last;
  logic [CNT_W-1:0]        w_len_sel, w_len_eff;

  always_comb begin
    w_s = '0;
    for (int l = 0; l < LANES; l++) w_s = w_s + SW'($signed(w_p[l]));
  end

  assign w_s_ext               = ACC_W'(w_s);
  assign {w_t_sat, w_t}        = sat_add(w_s_ext, r_casc_pipe[1]);
  assign {w_acc_sat, w_acc_sum} = sat_add(r_acc, w_s_ext);

  // First sample of an accumulation loads S directly and latches the length.
  assign w_len_sel  = (r_cnt == '0) ? i_acc_len : r_len_q;
  assign w_len_eff  = (w_len_sel == '0) ? CNT_W'(1) : w_len_sel;
  assign w_last     = (r_cnt == w_len_eff - CNT_W'(1));
  assign w_acc_next = (r_cnt == '0) ? w_s_ext : w_acc_sum;
  assign w_step_ovf = (r_cnt != '0) && w_acc_sat;
  assign w_ovf_all  = ((r_cnt != '0) && r_ovf_acc) || w_step_ovf;

  logic              w_nv, w_novf, w_novfa;
  logic [RW-1:0]     w_nres;
  logic [ACC_W-1:0]  w_ncasc, w_nacc;
  logic [CNT_W-1:0]  w_ncnt, w_nlen;

  always_comb begin
    w_nv    = 1'b0;
    w_nres  = o_result;
    w_ncasc = o_cascade_out;
    w_novf  = o_ovf;
    w_ncnt  = r_cnt;
    w_nacc  = r_acc;
    w_nlen  = r_len_q;
    w_novfa = r_ovf_acc;
    if (i_clear) begin
      w_ncnt  = '0;
      w_nacc  = '0;
      w_novfa = 1'b0;
    end
    if (r_vld_pipe[1]) begin
      if (r_mode_pipe[1] != 2'b11) begin
        // Non-accumulate sample: drop any partial accumulation, always emit.
        w_ncnt  = '0;
        w_novfa = 1'b0;
        w_nv    = 1'b1;
        case (r_mode_pipe[1])
          2'b00: begin
            w_nres  = w_p;
            w_ncasc = '0;
            w_novf  = 1'b0;
          end
          2'b01: begin
            w_nres  = sext_r(w_s_ext);
            w_ncasc = w_s_ext;
            w_novf  = 1'b0;
          end
          default: begin
            w_nres  = sext_r(w_t);
            w_ncasc = w_t;
            w_novf  = w_t_sat;
          end
        endcase
      end else if (!i_clear) begin
        w_nacc = w_acc_next;
        if (r_cnt == '0) w_nlen = i_acc_len;
        if (w_last) begin
          w_nv    = 1'b1;
          w_nres  = sext_r(w_acc_next);
          w_ncasc = w_acc_next;
          w_novf  = w_ovf_all;
          w_ncnt  = '0;
          w_novfa = 1'b0;
        end else begin
          w_ncnt  = r_cnt + CNT_W'(1);
          w_novfa = w_ovf_all;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_valid   <= 1'b0;
      o_result      <= '0;
      o_cascade_out <= '0;
      o_ovf         <= 1'b0;
      r_cnt         <= '0;
      r_len_q       <= '0;
      r_acc         <= '0;
      r_ovf_acc     <= 1'b0;
    end else begin
      o_out_valid   <= w_nv;
      o_result      <= w_nres;
      o_cascade_out <= w_ncasc;
      o_ovf         <= w_novf;
      r_cnt         <= w_ncnt;
      r_len_q       <= w_nlen;
      r_acc         <= w_nacc;
      r_ovf_acc     <= w_novfa;
    end
  end
endmodule

// File: tb/tb_dsp_mac_chain.sv
// Scoreboard bench for dsp_mac_chain: an integer-arithmetic model predicts each
// output (with its expected arrival cycle) into a queue; a negedge monitor pops
// and compares whenever the DUT raises o_out_valid.
module tb_dsp_mac_chain;
  localparam int IN_W  = 18;
  localparam int LANES = 4;
  localparam int ACC_W = 44;
  localparam int CNT_W = 8;
  localparam int PW    = 2 * IN_W;
  localparam int RW    = LANES * PW;
  localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam longint AMIN = -(64'sd1 <<< (ACC_W - 1));

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic [LANES*IN_W-1:0] a, b;
  logic [1:0]            mode;
  logic [ACC_W-1:0]      cascade_in;
  logic [CNT_W-1:0]      acc_len;
  logic                  clear;
  logic                  out_valid;
  logic [RW-1:0]         result;
  logic [ACC_W-1:0]      cascade_out;
  logic                  ovf;

  dsp_mac_chain #(.IN_W(IN_W), .LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_a(a), .i_b(b),
    .i_mode(mode), .i_cascade_in(cascade_in), .i_acc_len(acc_len), .i_clear(clear),
    .o_out_valid(out_valid), .o_result(result), .o_cascade_out(cascade_out), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int unsigned     cyc;
    logic [RW-1:0]   res;
    logic [ACC_W-1:0] casc;
    logic            ovf;
  } exp_t;
  exp_t q[$];

  typedef struct {
    bit                    v;
    logic [1:0]            mode;
    logic [LANES*IN_W-1:0] a, b;
    longint                casc;
  } smp_t;

  smp_t   dl0, dl1;          // samples issued one and two cycles ago
  int     m_cnt, m_len;
  longint m_acc;
  bit     m_ovf;

  function automatic smp_t smp_zero();
    smp_t s;
    s.v = 0; s.mode = '0; s.a = '0; s.b = '0; s.casc = 0;
    return s;
  endfunction

  function automatic longint sat(input longint x, output bit o);
    o = 1'b0;
    if (x > AMAX) begin o = 1'b1; return AMAX; end
    if (x < AMIN) begin o = 1'b1; return AMIN; end
    return x;
  endfunction

  function automatic longint prod(input smp_t s, input int i);
    logic signed [IN_W-1:0] x, y;
    x = s.a[i*IN_W +: IN_W];
    y = s.b[i*IN_W +: IN_W];
    return longint'(x) * longint'(y);
  endfunction

  function automatic logic [LANES*IN_W-1:0] vec_all(input int val);
    logic [LANES*IN_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*IN_W +: IN_W] = IN_W'(val);
    return v;
  endfunction

  function automatic logic [LANES*IN_W-1:0] vec_l0(input int val);
    logic [LANES*IN_W-1:0] v;
    v = '0;
    v[IN_W-1:0] = IN_W'(val);
    return v;
  endfunction

  task automatic push(input logic [RW-1:0] r, input logic [ACC_W-1:0] c, input bit o);
    exp_t e;
    e.cyc = cyc + 1; e.res = r; e.casc = c; e.ovf = o;
    q.push_back(e);
  endtask

  // Model of the sample reaching stage 3 this cycle, using this cycle's clear/acc_len.
  task automatic model_step(input smp_t cur, input bit clr, input int alen);
    smp_t s;
    longint S, t, nx;
    bit o, so;
    logic signed [RW-1:0] r;
    logic [RW-1:0] pr;
    s = dl1; dl1 = dl0; dl0 = cur;
    if (clr) begin m_cnt = 0; m_acc = 0; m_ovf = 0; end
    if (!s.v) return;
    S = 0;
    for (int i = 0; i < LANES; i++) begin
      S += prod(s, i);
      pr[i*PW +: PW] = PW'(prod(s, i));
    end
    case (s.mode)
      2'd0: begin m_cnt = 0; m_ovf = 0; push(pr, '0, 1'b0); end
      2'd1: begin m_cnt = 0; m_ovf = 0; r = S; push(r, ACC_W'(S), 1'b0); end
      2'd2: begin
        m_cnt = 0; m_ovf = 0;
        t = sat(S + s.casc, o);
        r = t;
        push(r, ACC_W'(t), o);
      end
      default: if (!clr) begin
        so = 1'b0;
        if (m_cnt == 0) begin
          m_len = (alen == 0) ? 1 : alen;
          nx = S;
          m_ovf = 0;
        end else nx = sat(m_acc + S, so);
        m_ovf = m_ovf | so;
        m_acc = nx;
        if (m_cnt == m_len - 1) begin
          r = nx;
          push(r, ACC_W'(nx), m_ovf);
          m_cnt = 0; m_ovf = 0;
        end else m_cnt++;
      end
    endcase
  endtask

  task automatic drive(input bit v, input logic [1:0] md, input logic [LANES*IN_W-1:0] va,
                       input logic [LANES*IN_W-1:0] vb, input longint c, input int alen,
                       input bit clr);
    smp_t s;
    in_valid = v; mode = md; a = va; b = vb; cascade_in = ACC_W'(c);
    acc_len = CNT_W'(alen); clear = clr;
    s.v = v; s.mode = md; s.a = va; s.b = vb; s.casc = c;
    model_step(s, clr, alen);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input int alen);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, '0, '0, 0, alen, 1'b0);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (out_valid !== 1'b0 || result !== '0 || cascade_out !== '0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL %s: got vld=%b res=%h casc=%h ovf=%b, required all zero",
               name, out_valid, result, cascade_out, ovf);
    end
  endtask

  task automatic check_drain(input string name);
    idle(5, 0);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected outputs never appeared, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    in_valid = 0; clear = 0;
    rst_n = 1'b0;
    q.delete();
    dl0 = smp_zero(); dl1 = smp_zero();
    m_cnt = 0; m_len = 0; m_acc = 0; m_ovf = 0;
    #2;
    check_zero("reset_async");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("reset_release");
  endtask

  // Monitor: one comparison per presented output.
  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: cyc=%0d res=%h casc=%h ovf=%b, required no output",
                 cyc, result, cascade_out, ovf);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || result !== e.res || cascade_out !== e.casc || ovf !== e.ovf) begin
          fails++;
          $display("FAIL out: got cyc=%0d res=%h casc=%h ovf=%b, required cyc=%0d res=%h casc=%h ovf=%b",
                   cyc, result, cascade_out, ovf, e.cyc, e.res, e.casc, e.ovf);
        end
      end
    end
  end

  initial begin
    logic [LANES*IN_W-1:0] ra, rb;
    logic signed [ACC_W-1:0] rc;
    int m, al;
    rst_n = 1'b0; in_valid = 0; a = '0; b = '0; mode = '0; cascade_in = '0;
    acc_len = '0; clear = 0;
    dl0 = smp_zero(); dl1 = smp_zero();
    m_cnt = 0; m_len = 0; m_acc = 0; m_ovf = 0;
    #12;
    check_zero("reset_initial");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single-lane product
    drive(1, 2'd0, vec_l0(3), vec_l0(-2), 0, 0, 0);
    check_drain("mode00");

    // back-to-back sums
    for (int i = 0; i < 4; i++) drive(1, 2'd1, vec_all(100), vec_all(200), 0, 0, 0);
    check_drain("mode01");

    // cascade add with saturation at both ends
    drive(1, 2'd2, vec_all(100), vec_all(200), 1000, 0, 0);
    drive(1, 2'd2, vec_all(100), vec_all(200), AMAX, 0, 0);
    drive(1, 2'd2, vec_all(-100), vec_all(200), AMIN, 0, 0);
    drive(1, 2'd2, vec_all(-100), vec_all(200), -5000, 0, 0);
    check_drain("mode10");

    // accumulate len 4, then len 0 (every sample emits)
    for (int i = 0; i < 4; i++) drive(1, 2'd3, vec_l0(5), vec_l0(1), 0, 4, 0);
    idle(3, 4);
    for (int i = 0; i < 3; i++) drive(1, 2'd3, vec_l0(5), vec_l0(1), 0, 0, 0);
    check_drain("mode11_len");

    // two samples, clear, four samples -> 4
    for (int i = 0; i < 2; i++) drive(1, 2'd3, vec_l0(5), vec_l0(1), 0, 4, 0);
    idle(2, 4);
    drive(0, 2'd0, '0, '0, 0, 4, 1);
    for (int i = 0; i < 4; i++) drive(1, 2'd3, vec_l0(1), vec_l0(1), 0, 4, 0);
    check_drain("mode11_clear");

    // clear coinciding with an accumulate sample (discarded) and a sum sample (kept)
    drive(1, 2'd3, vec_l0(7), vec_l0(1), 0, 2, 0);
    drive(1, 2'd1, vec_l0(9), vec_l0(1), 0, 2, 0);
    drive(0, 2'd0, '0, '0, 0, 2, 1);
    drive(0, 2'd0, '0, '0, 0, 2, 1);
    for (int i = 0; i < 2; i++) drive(1, 2'd3, vec_l0(3), vec_l0(1), 0, 2, 0);
    check_drain("clear_overlap");

    // reset mid-accumulation, then a fresh accumulation
    for (int i = 0; i < 2; i++) drive(1, 2'd3, vec_l0(5), vec_l0(1), 0, 4, 0);
    idle(2, 4);
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 2'd3, vec_l0(1), vec_l0(1), 0, 4, 0);
    check_drain("mode11_reset");

    // in-flight data must not survive reset
    drive(1, 2'd1, vec_all(11), vec_all(13), 0, 0, 0);
    drive(1, 2'd1, vec_all(11), vec_all(13), 0, 0, 0);
    do_reset();
    check_drain("flush_on_reset");

    // abandon partial accumulation with a non-accumulate sample
    for (int i = 0; i < 2; i++) drive(1, 2'd3, vec_l0(5), vec_l0(1), 0, 4, 0);
    drive(1, 2'd1, vec_l0(2), vec_l0(3), 0, 4, 0);
    for (int i = 0; i < 4; i++) drive(1, 2'd3, vec_l0(2), vec_l0(1), 0, 4, 0);
    check_drain("abandon");

    // longest accumulation with maximal products saturates positive
    for (int i = 0; i < 255; i++)
      drive(1, 2'd3, vec_all(-(1 << (IN_W - 1))), vec_all(-(1 << (IN_W - 1))), 0, 255, 0);
    check_drain("mode11_maxlen_sat");

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < LANES; i++) begin
        ra[i*IN_W +: IN_W] = IN_W'($urandom());
        rb[i*IN_W +: IN_W] = IN_W'($urandom());
      end
      case ($urandom_range(0, 3))
        0: rc = ACC_W'(AMAX - longint'($urandom_range(0, 1 << 20)));
        1: rc = ACC_W'(AMIN + longint'($urandom_range(0, 1 << 20)));
        default: rc = ACC_W'({$urandom(), $urandom()});
      endcase
      m  = $urandom_range(0, 3);
      al = $urandom_range(0, 5);
      drive($urandom_range(0, 9) < 7, 2'(m), ra, rb, longint'(rc), al,
            $urandom_range(0, 19) == 0);
    end
    check_drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
